regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (isWrite / A3 / writeData) between NUM_REQ writeback requesters, e.g. ALU result, load data and debug/host poke.
- Uses a round-robin valid/ready handshake.
- Registers the winning write for one cycle, then drives it straight into the register file.
- Keeps a running count of committed writes for bring-up visibility.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter and its
// round-robin arbiter core: register geometry, the PC register index and
// the grant index type with its wrap helper.
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_PC_IDX = 4'hF;

    // Wide enough for up to 8 requesters.
    typedef logic [2:0] grant_idx_t;

    // Next round-robin pointer after cur won. The wrap is explicit so that
    // non-power-of-two requester counts never leave an out-of-range pointer.
    function automatic grant_idx_t rr_next(input grant_idx_t cur, input int num_req);
        if (int'(cur) >= num_req - 1) begin
            return '0;
        end
        return cur + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter core. Scans the request vector starting at ptr,
// wrapping modulo NUM_REQ, and returns a one-hot grant for the first set
// request plus its binary index. Purely combinational and reusable for
// other shared ports. ptr must be below NUM_REQ.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  grant_idx_t         ptr,
    output logic [NUM_REQ-1:0] grant,
    output grant_idx_t         winner,
    output logic               any_grant
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [3:0]       pos;
    logic [IDX_W-1:0] idx;

    // Walk the requesters in priority order starting at ptr; first hit wins.
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = {1'b0, ptr} + 4'(off);
            if (pos >= 4'(NUM_REQ)) begin
                pos = pos - 4'(NUM_REQ);
            end
            idx = pos[IDX_W-1:0];
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                winner     = grant_idx_t'(pos);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between NUM_REQ writeback
// requesters using a round-robin valid/ready handshake. The winning write
// is registered for one cycle and then presented on isWrite/A3/writeData.
// write_count tracks every write presented to the register file.
//
// Optional feature: define REGFILE_PC_PROTECT_EN to drop writes to R15 (the
// PC, owned by fetch logic). A dropped write still completes its handshake
// but leaves isWrite low, pulses pc_write_drop and does not count.
// NUM_REQ is legal from 2 to 8.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      isWrite,
    output logic [ADDR_W-1:0]         A3,
    output logic [DATA_W-1:0]         writeData,
    output grant_idx_t                grant_id,
    output logic [CNT_W-1:0]          write_count,
    output logic                      pc_write_drop
);

    grant_idx_t          rr_ptr;
    logic [NUM_REQ-1:0]  grant_p0;
    grant_idx_t          winner_p0;
    logic                any_p0;
    logic                xfer_p0;
    logic                pc_hit_p0;
    logic                commit_p0;
    logic [ADDR_W-1:0]   win_addr_p0;
    logic [DATA_W-1:0]   win_data_p0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant_p0),
        .winner    (winner_p0),
        .any_grant (any_p0)
    );

    // Grants are suppressed while reset is held so nobody believes it transferred.
    assign req_ready = reset ? '0 : grant_p0;
    assign xfer_p0   = any_p0 && !reset;

    // One-hot mux of the winning requester's address and data.
    always_comb begin
        win_addr_p0 = '0;
        win_data_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_p0[i]) begin
                win_addr_p0 = req_addr[i*ADDR_W +: ADDR_W];
                win_data_p0 = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REGFILE_PC_PROTECT_EN
    assign pc_hit_p0 = (win_addr_p0 == ADDR_W'(REG_PC_IDX));
`else
    assign pc_hit_p0 = 1'b0;
`endif

    assign commit_p0 = xfer_p0 && !pc_hit_p0;

    // ---- p0 -> p1: register the winning write and advance the pointer ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            isWrite   <= 1'b0;
            A3        <= '0;
            writeData <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else begin
            isWrite <= commit_p0;
            if (xfer_p0) begin
                A3        <= win_addr_p0;
                writeData <= win_data_p0;
                grant_id  <= winner_p0;
                rr_ptr    <= rr_next(winner_p0, NUM_REQ);
            end
        end
    end

    // Count moves together with isWrite rising for each presented write, wrapping freely.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_count <= '0;
        end else if (commit_p0) begin
            write_count <= write_count + 1'b1;
        end
    end

`ifdef REGFILE_PC_PROTECT_EN
    // One-cycle flag marking a handshake whose R15 write was discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_write_drop <= 1'b0;
        end else begin
            pc_write_drop <= xfer_p0 && pc_hit_p0;
        end
    end
`else
    assign pc_write_drop = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: fixed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int CW = 16;
`ifdef REGFILE_PC_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              isWrite;
    logic [AW-1:0]     A3;
    logic [DW-1:0]     writeData;
    grant_idx_t        grant_id;
    logic [CW-1:0]     write_count;
    logic              pc_write_drop;

    regfile_write_arbiter #(
        .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .CNT_W (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .isWrite       (isWrite),
        .A3            (A3),
        .writeData     (writeData),
        .grant_id      (grant_id),
        .write_count   (write_count),
        .pc_write_drop (pc_write_drop)
    );

    always #5 clock = ~clock;

    // Register file as seen by the consumer of the write port.
    logic [DW-1:0] rf_obs [16];
    always @(posedge clock) begin
        if (isWrite === 1'b1) rf_obs[A3] <= writeData;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_ptr;
    logic          m_isw;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;
    int            m_gid;
    int            m_cnt;
    logic          m_drop;

    task automatic model_reset();
        m_ptr = 0; m_isw = 0; m_a3 = '0; m_wd = '0; m_gid = 0; m_cnt = 0; m_drop = 0;
    endtask

    // First valid requester in circular order from ptr, or -1.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Called with inputs already driven after an edge; checks ready, clocks, checks outputs.
    task automatic cycle(output int w);
        logic [N-1:0]  er;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        #1;
        w  = pick(req_valid, m_ptr);
        er = '0;
        wa = '0;
        wd = '0;
        if (w >= 0) begin
            er[w] = 1'b1;
            wa = req_addr[w*AW +: AW];
            wd = req_data[w*DW +: DW];
        end
        chk("ready", 64'(req_ready), 64'(er));
        @(posedge clock);
        if (w >= 0) begin
            m_a3  = wa;
            m_wd  = wd;
            m_gid = w;
            m_ptr = (w + 1) % N;
            if (PROTECT && wa == 4'hF) begin
                m_isw  = 0;
                m_drop = 1;
            end else begin
                m_isw  = 1;
                m_drop = 0;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end
        end else begin
            m_isw  = 0;
            m_drop = 0;
        end
        #1;
        chk("isWrite", 64'(isWrite), 64'(m_isw));
        chk("A3", 64'(A3), 64'(m_a3));
        chk("writeData", 64'(writeData), 64'(m_wd));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("write_count", 64'(write_count), 64'(m_cnt));
        chk("pc_write_drop", 64'(pc_write_drop), 64'(m_drop));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]    v;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        logic [N-1:0]    exp_ready;
        logic            exp_isw;
        logic [AW-1:0]   exp_a3;
        logic [DW-1:0]   exp_wd;
        logic [2:0]      exp_gid;
        logic [CW-1:0]   exp_cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int w;
        logic          pend [N];
        logic [AW-1:0] pa [N];
        logic [DW-1:0] pd [N];
        int            waited [N];

        // Single request from req0, then req2 alone to bring the pointer back to 0.
        tbl[0] = '{3'b001, 12'h004, {32'd0, 32'd0, 32'd2},   3'b001, 1'b1, 4'd4, 32'd2, 3'd0, 16'd1};
        tbl[1] = '{3'b100, 12'h900, {32'd3, 32'd0, 32'd0},   3'b100, 1'b1, 4'd9, 32'd3, 3'd2, 16'd2};
        // All three valid for six cycles: grants 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            tbl[2+i] = '{3'b111, 12'h321, {32'd30, 32'd20, 32'd10}, 3'(1 << (i % 3)), 1'b1,
                         4'((i % 3) + 1), 32'(10 * ((i % 3) + 1)), 3'(i % 3), 16'(3 + i)};
        end
        // req0 moves the pointer to 1, then req1/req2 collide on R7.
        tbl[8]  = '{3'b001, 12'h000, {32'd0, 32'd0, 32'd5},   3'b001, 1'b1, 4'd0, 32'd5,  3'd0, 16'd9};
        tbl[9]  = '{3'b110, 12'h770, {32'd22, 32'd11, 32'd0}, 3'b010, 1'b1, 4'd7, 32'd11, 3'd1, 16'd10};
        tbl[10] = '{3'b100, 12'h770, {32'd22, 32'd11, 32'd0}, 3'b100, 1'b1, 4'd7, 32'd22, 3'd2, 16'd11};
        tbl[11] = '{3'b000, 12'h770, {32'd22, 32'd11, 32'd0}, 3'b000, 1'b0, 4'd7, 32'd22, 3'd2, 16'd11};

        // Reset state, with all requesters valid so the ready mask is exercised.
        reset = 1'b1;
        req_valid = 3'b111;
        @(posedge clock);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_isWrite", 64'(isWrite), 64'd0);
        chk("rst_A3", 64'(A3), 64'd0);
        chk("rst_writeData", 64'(writeData), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_write_count", 64'(write_count), 64'd0);
        chk("rst_pc_write_drop", 64'(pc_write_drop), 64'd0);
        req_valid = '0;
        reset = 1'b0;

        for (int r = 0; r < 12; r++) begin
            req_valid = tbl[r].v;
            req_addr  = tbl[r].a;
            req_data  = tbl[r].d;
            #1;
            chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
            @(posedge clock);
            #1;
            chk($sformatf("tbl%0d_isWrite", r), 64'(isWrite), 64'(tbl[r].exp_isw));
            chk($sformatf("tbl%0d_A3", r), 64'(A3), 64'(tbl[r].exp_a3));
            chk($sformatf("tbl%0d_writeData", r), 64'(writeData), 64'(tbl[r].exp_wd));
            chk($sformatf("tbl%0d_grant_id", r), 64'(grant_id), 64'(tbl[r].exp_gid));
            chk($sformatf("tbl%0d_write_count", r), 64'(write_count), 64'(tbl[r].exp_cnt));
        end
        chk("R7_final", 64'(rf_obs[7]), 64'd22);

        // Reset asserted while a write is on the port.
        do_reset();
        req_valid = 3'b001;
        req_addr  = 12'h005;
        req_data  = {32'd0, 32'd0, 32'h55};
        @(posedge clock);
        #1;
        chk("mid_isWrite_before", 64'(isWrite), 64'd1);
        req_valid = 3'b111;
        req_addr  = 12'h321;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_isWrite", 64'(isWrite), 64'd0);
        chk("mid_A3", 64'(A3), 64'd0);
        chk("mid_write_count", 64'(write_count), 64'd0);
        chk("mid_ready", 64'(req_ready), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_restart_ready", 64'(req_ready), 64'b001);
        @(posedge clock);
        #1;
        chk("mid_restart_gid", 64'(grant_id), 64'd0);
        chk("mid_restart_isWrite", 64'(isWrite), 64'd1);

        // Counter wrap: 65535 writes then one more.
        do_reset();
        req_valid = 3'b001;
        req_addr  = 12'h001;
        req_data  = {32'd0, 32'd0, 32'h77};
        for (int i = 0; i < 65535; i++) @(posedge clock);
        #1;
        chk("cnt_65535", 64'(write_count), 64'd65535);
        @(posedge clock);
        #1;
        chk("cnt_wrap", 64'(write_count), 64'd0);
        req_valid = '0;

        // R15 write from req2.
        do_reset();
        req_valid = 3'b100;
        req_addr  = 12'hF00;
        req_data  = {32'hDEAD, 32'd0, 32'd0};
        #1;
        chk("pc_ready", 64'(req_ready), 64'b100);
        @(posedge clock);
        #1;
        req_valid = '0;
`ifdef REGFILE_PC_PROTECT_EN
        chk("pc_isWrite", 64'(isWrite), 64'd0);
        chk("pc_drop", 64'(pc_write_drop), 64'd1);
        chk("pc_count", 64'(write_count), 64'd0);
        @(posedge clock);
        #1;
        chk("pc_drop_clear", 64'(pc_write_drop), 64'd0);
`else
        chk("pc_isWrite", 64'(isWrite), 64'd1);
        chk("pc_A3", 64'(A3), 64'hF);
        chk("pc_drop", 64'(pc_write_drop), 64'd0);
        chk("pc_count", 64'(write_count), 64'd1);
`endif

        // Randomized traffic against the model, with requesters obeying hold rules.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pd[i] = '0; waited[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]   = 1'b1;
                    pa[i]     = 4'($urandom_range(0, 15));
                    pd[i]     = $urandom;
                    waited[i] = 0;
                end
                req_valid[i] = pend[i];
                req_addr[i*AW +: AW] = pa[i];
                req_data[i*DW +: DW] = pd[i];
            end
            cycle(w);
            for (int i = 0; i < N; i++) begin
                if (pend[i] && i == w) begin
                    chk($sformatf("fair%0d", i), 64'(waited[i] <= N - 1), 64'd1);
                    pend[i] = 1'b0;
                end else if (pend[i]) begin
                    waited[i]++;
                end
            end
        end
        req_valid = '0;
        cycle(w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case something stalls the sequence.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
